// File: rtl/ex_mdu.sv
// Execute stage: registered single-cycle ALU plus an iterative unsigned multiply/divide
// unit with HI/LO registers. Holds off upstream (in_ready low) while an iteration runs.
module ex_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   i_ex_aluop,
    input  logic [DATA_W-1:0] i_ex_rs_data,
    input  logic [DATA_W-1:0] i_ex_rt_data,
    input  logic [REG_AW-1:0] i_ex_w_reg_addr,
    input  logic              i_ex_wd,
    input  logic              ex_inst_in_delayslot,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] w_reg_data,
    output logic [REG_AW-1:0] w_reg_addr,
    output logic              wd,
    output logic              stall_req
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(8'h0D);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(8'h0F);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(8'h10);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(8'h12);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(8'h19);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(8'h1B);
    localparam logic [OP_W-1:0] OP_ADDU  = OP_W'(8'h21);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(8'h24);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(8'h25);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(8'h26);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(8'h2B);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    state_t state_q, state_d;
    logic [SH_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                vld_q, vld_d, wd_q, wd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;

    logic                accept, start_mul, start_div;
    logic [SH_W-1:0]     shamt;
    logic signed [DATA_W-1:0] rt_s;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_known;
    logic [2*DATA_W-1:0] prod_step;
    logic [DATA_W:0]     rem_sh, rem_diff;
    logic                div_ok;
    logic [DATA_W-1:0]   rem_step, quot_step;

    assign accept    = in_valid && (state_q == S_IDLE) && !flush;
    assign start_mul = accept && !ex_inst_in_delayslot && (i_ex_aluop == OP_MULTU);
    assign start_div = accept && !ex_inst_in_delayslot && (i_ex_aluop == OP_DIVU)
                       && (i_ex_rt_data != '0);

    assign shamt = i_ex_rs_data[SH_W-1:0];
    assign rt_s  = i_ex_rt_data;

    always_comb begin
        alu_res   = '0;
        alu_known = 1'b1;
        case (i_ex_aluop)
            OP_ADDU: alu_res = i_ex_rs_data + i_ex_rt_data;
            OP_ORI,
            OP_OR:   alu_res = i_ex_rs_data | i_ex_rt_data;
            OP_AND:  alu_res = i_ex_rs_data & i_ex_rt_data;
            OP_XOR:  alu_res = i_ex_rs_data ^ i_ex_rt_data;
            OP_LUI:  alu_res = i_ex_rt_data;
            OP_SLL:  alu_res = i_ex_rt_data << shamt;
            OP_SRL:  alu_res = i_ex_rt_data >> shamt;
            OP_SRA:  alu_res = rt_s >>> shamt;
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (i_ex_rs_data < i_ex_rt_data)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_known = 1'b0;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step per cycle
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign rem_sh    = {rem_q, quot_q[DATA_W-1]};
    assign rem_diff  = rem_sh - {1'b0, dvsr_q};
    assign div_ok    = !rem_diff[DATA_W];
    assign rem_step  = div_ok ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quot_step = {quot_q[DATA_W-2:0], div_ok};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul)      state_d = S_MUL;
                else if (start_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (flush || (cnt_q == CNT_LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        stall_req = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        vld_d    = 1'b0;
        data_d   = '0;
        addr_d   = '0;
        wd_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vld_d = 1'b1;
                    if (start_mul) begin
                        vld_d    = 1'b0;
                        mcand_d  = {{DATA_W{1'b0}}, i_ex_rs_data};
                        mplier_d = i_ex_rt_data;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else if (start_div) begin
                        vld_d  = 1'b0;
                        quot_d = i_ex_rs_data;
                        dvsr_d = i_ex_rt_data;
                        rem_d  = '0;
                        cnt_d  = '0;
                    end else if (!ex_inst_in_delayslot) begin
                        // divu reaching here has a zero divisor and finishes immediately
                        if (i_ex_aluop == OP_DIVU) begin
                            hi_d = i_ex_rs_data;
                            lo_d = '1;
                        end else begin
                            data_d = alu_res;
                            addr_d = alu_known ? i_ex_w_reg_addr : '0;
                            wd_d   = alu_known && i_ex_wd;
                        end
                    end
                end
            end
            S_MUL: begin
                if (!flush) begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SH_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        hi_d  = prod_step[2*DATA_W-1:DATA_W];
                        lo_d  = prod_step[DATA_W-1:0];
                        vld_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                if (!flush) begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    cnt_d  = cnt_q + SH_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        hi_d  = rem_step;
                        lo_d  = quot_step;
                        vld_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            wd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            addr_q <= addr_d;
            wd_q   <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
        quot_q   <= quot_d;
        rem_q    <= rem_d;
        dvsr_q   <= dvsr_d;
    end

    assign out_valid  = vld_q;
    assign w_reg_data = data_q;
    assign w_reg_addr = addr_q;
    assign wd         = wd_q;

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute stage that supersedes the single-cycle EX block. It keeps the registered single-cycle ALU path, adds shift-right and compare ops, and adds an iterative unsigned multiply/divide unit with HI/LO registers. It sits between the ID/EX pipeline register and EX/MEM. While a multiply or divide is in flight, it holds off upstream with a ready/stall handshake.

## Interface
- DATA_W, 32, operand/result width; must be a power of two, at least 8
- REG_AW, 5, destination register address width
- OP_W, 8, aluop width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  ID/EX presents an instruction
- in_ready  out  1  EX can accept; high only in IDLE
- i_ex_aluop  in  OP_W  operation code
- i_ex_rs_data, i_ex_rt_data  in  DATA_W  operands
- i_ex_w_reg_addr  in  REG_AW  destination register
- i_ex_wd  in  1  destination write enable
- ex_inst_in_delayslot  in  1  instruction is a delay-slot instruction; it is squashed to a bubble
- flush  in  1  abort any in-flight operation and drop the current input
- out_valid  out  1  one-cycle pulse per completed instruction
- w_reg_data  out  DATA_W  result
- w_reg_addr  out  REG_AW  destination register
- wd  out  1  register-write enable to EX/MEM
- stall_req  out  1  equals !in_ready; goes to pipeline control

## Operation
- An instruction is accepted on a rising edge where rst=1, in_valid=1, in_ready=1 and flush=0.
- Single-cycle ops, result registered:
  - 0x21 addu: rs+rt, modulo 2^DATA_W
  - 0x0D ori: rs|rt
  - 0x24 and: rs&rt
  - 0x25 or: rs|rt
  - 0x26 xor: rs^rt
  - 0x0F lui: rt
  - 0x00 sll: rt << rs[log2(DATA_W)-1:0]
  - 0x02 srl: logical right shift, same shift amount
  - 0x03 sra: arithmetic right shift, same shift amount
  - 0x2B sltu: {0…, rs<rt unsigned}
  - 0x10 mfhi: HI
  - 0x12 mflo: LO
- Unknown opcode: result 0, wd=0, out_valid=1.
- Delay-slot squash: an accepted instruction with ex_inst_in_delayslot=1 produces out_valid=1, w_reg_data=0, w_reg_addr=0, wd=0. A squashed multiply or divide starts nothing.
- 0x19 multu: shift-add, one bit per cycle, 2·DATA_W-bit product; HI=upper half, LO=lower half.
- 0x1B divu: restoring division, one bit per cycle; LO=quotient, HI=remainder.
  - Divisor zero: completes in one cycle with HI=dividend, LO=all ones.
- multu and divu always complete with wd=0, w_reg_addr=0, w_reg_data=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL or IDLE→DIV on acceptance of a non-squashed multu or divu (nonzero divisor); cnt←0 and operands are latched.
  - MUL/DIV: one iteration per cycle, cnt increments.
  - When cnt reaches DATA_W-1: write HI/LO, pulse out_valid, return to IDLE.
  - flush in MUL/DIV: return to IDLE at that edge; HI/LO unchanged, out_valid=0.
- flush in IDLE: nothing is accepted; outputs go to the bubble state (out_valid=0, wd=0).
- Reset (rst=0) at any edge, including mid-operation: state=IDLE, cnt=0, HI=LO=0, out_valid=0, w_reg_data=0, w_reg_addr=0, wd=0.

## Timing
- Single-cycle ops: accepted at edge N, outputs valid after edge N, held for one cycle only; out_valid deasserts at N+1 unless a new instruction is accepted.
- Back-to-back single-cycle ops sustain one per cycle; in_ready stays 1.
- multu/divu accepted at edge N:
  - in_ready=0 and stall_req=1 from after edge N through edge N+DATA_W.
  - HI/LO updated and out_valid pulses after edge N+DATA_W.
  - in_ready returns to 1 in that same cycle.
- mfhi/mflo accepted in the first ready cycle after a multu/divu sees the new HI/LO; no forwarding hazard.
- Simultaneous flush and in_valid: flush wins, nothing is accepted.
- Simultaneous rst=0 and flush: reset wins.
- in_valid while in_ready=0 is ignored. Upstream must hold its instruction until acceptance.

## Test plan
- Reset mid-multiply: after multu 7×9 is accepted, drive rst=0 for one cycle -> all outputs 0, HI=LO=0, in_ready=1 on the next cycle.
- ALU sweep, DATA_W=32:
  - addu 0xFFFFFFFF+2 -> 0x00000001
  - sll rt=1, rs=35 -> 0x00000008
  - sra 0x80000000 by 4 -> 0xF8000000
  - sltu 1<2 -> 1
  - each with wd and addr passed through
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - stall_req high for 32 cycles, out_valid 32 cycles after acceptance
  - HI=0xFFFFFFFE, LO=0x00000001
  - following mflo/mfhi return those values
- divu 100/7 -> LO=14, HI=2 after 32 cycles; divu 5/0 -> LO=0xFFFFFFFF, HI=5, out_valid one cycle after acceptance.
- flush at cycle 10 of divu 100/7 -> no out_valid; HI/LO keep prior values; next addu is accepted the cycle after flush.
- Delay-slot addu with wd=1, addr=3 -> out_valid=1, wd=0, addr=0, data=0; a delay-slot multu leaves in_ready=1 and HI/LO unchanged.
